branch_predictor: RTL
=====================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the D-stage "assume not-taken" resolution with a pattern-history table (PHT) of 2-bit saturating counters, looked up in D and trained in E. The table is indexed bimodally or gshare-style, selected by parameter. The block keeps a speculative global history register (GHR) with single-cycle repair on mispredict, and exposes branch and mispredict statistics counters to the debug path.

## Interface
- `IDX_W`, 6: PHT index width; the table holds 2^IDX_W counters.
- `GHR_W`, 6: history length; legal range is 1..IDX_W.
- `MODE`, 1: 0 = static not-taken, 1 = bimodal, 2 = gshare.
- `CNT_INIT`, 2'b01: reset value of every counter.
- `clk  in  1`: clock; all state updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `lookup_enD  in  1`: a branch instruction is in the D stage.
- `stallD  in  1`: the D stage is stalled.
- `pcD  in  32`: PC of the D-stage branch.
- `predict_takeD  out  1`: prediction for the D-stage branch.
- `ghr_snapD  out  GHR_W`: GHR value used for this lookup; the pipeline carries it to E.
- `update_enE  in  1`: the E-stage branch has resolved.
- `pcE  in  32`: PC of the resolved branch.
- `takenE  in  1`: actual outcome.
- `predictedE  in  1`: the prediction that was issued for this branch.
- `ghr_snapE  in  GHR_W`: snapshot carried down from D.
- `mispredictE  out  1`: `update_enE & (takenE != predictedE)`.
- `branch_cnt  out  32`: number of resolved branches.
- `mispred_cnt  out  32`: number of mispredicts.

## Operation
- **Index.**
  - Base index is `pc[IDX_W+1:2]`.
  - gshare XORs the base index with the GHR, zero-extended to IDX_W.
  - The lookup uses `pcD` and the current GHR. The update uses `pcE` and `ghr_snapE`, never the live GHR.
- **Prediction.**
  - `predict_takeD` = MSB of the indexed counter; it is combinational from state.
  - MODE 0: always 0. The PHT is never written and the GHR still operates.
  - `predict_takeD` is valid only while `lookup_enD` is high; otherwise it is don't-care. The bench checks it only when `lookup_enD` = 1.
  - `ghr_snapD` = current GHR.
- **Counter training** (on `update_enE`):
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
  - Exactly one entry changes per cycle.
- **GHR, in priority order:**
  1. Mispredict: `GHR <= {ghr_snapE[GHR_W-2:0], takenE}`. This is a repair; any same-cycle D lookup is ignored, because the D stage is being flushed.
  2. `lookup_enD & ~stallD`: `GHR <= {GHR[GHR_W-2:0], predict_takeD}` (speculative shift).
  3. Otherwise: hold.
  - With GHR_W = 1 the shift degenerates to assigning the single bit.
- **Statistics.**
  - `branch_cnt` increments on every `update_enE`.
  - `mispred_cnt` increments on every `mispredictE`.
  - Both wrap from 0xFFFFFFFF to 0 with no saturation.
- **Illegal configuration.** MODE = 3 behaves as MODE 0.

## Timing
- **Reset.** On a clock edge with `rst` = 1:
  - all counters go to CNT_INIT;
  - GHR, `branch_cnt` and `mispred_cnt` go to 0.
  - Reset wins over any same-cycle update or lookup.
  - If reset arrives mid-stream, in-flight snapshots are discarded (the pipeline is flushed by the same reset).
- **Outputs after reset.** `predict_takeD` = CNT_INIT[1], `ghr_snapD` = 0, `mispredictE` = 0 when `update_enE` = 0.
- **Latency.**
  - Prediction: 0 cycles (same cycle as `pcD`).
  - Counter, GHR and statistics writes become visible on the next cycle.
  - `mispredictE` is combinational in E, in the same cycle as `update_enE`.
- **Read/write collision.** A lookup and an update to the same index in the same cycle read the pre-update value. There is no bypass.
- **Stall.**
  - While `stallD` = 1, the GHR does not shift, so repeated lookups of a stalled branch see an identical snapshot.
  - Updates proceed regardless of `stallD`.
- **Handshake.** There is none. Each pulse of `update_enE` must correspond to exactly one branch that was accepted in D.

## Test plan
- **Reset defaults.** Reset, then lookup with `pcD` = 0xBFC00010 in MODE 1 -> `predict_takeD` = 0, `ghr_snapD` = 0, both counters = 0.
- **Training and saturation.** Three taken updates at 0xBFC00010 with `predictedE` = 0, 0, 1 -> counter steps 01→10→11→11; `mispred_cnt` = 2, `branch_cnt` = 3. Then one not-taken update -> counter = 10 and lookup still predicts 1.
- **GHR shift and repair.**
  - Three unstalled lookups predicting 1 -> GHR = 000111.
  - One stalled cycle -> GHR unchanged.
  - Then a mispredict with `ghr_snapE` = 000011 and `takenE` = 0, in the same cycle as a D lookup -> GHR = 000110 (repair wins).
- **gshare aliasing separation.** MODE 2: train PC 0x100 taken with snapshot 000000, and train PC 0x100 not-taken with snapshot 000001 -> the two lookups select different entries and return 1 and 0 respectively.
- **Collision and static mode.**
  - Lookup and update of the same index in one cycle -> the old counter MSB is returned.
  - MODE 0 with 10 taken updates -> `predict_takeD` stays 0 and `mispred_cnt` = 10.
- **Statistics wrap.** Force `branch_cnt` to 0xFFFFFFFF, then one update -> `branch_cnt` = 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Purpose : PHT of 2-bit saturating counters (static / bimodal / gshare) with speculative GHR and branch statistics.
// Latency : prediction is combinational in D; counter, GHR and statistics writes appear on the next cycle.
// Backpres: none; updates are taken every cycle they are presented, stallD only freezes the speculative GHR shift.
module branch_predictor #(
    parameter int          IDX_W    = 6,      // PHT index width, 2^IDX_W counters
    parameter int          GHR_W    = 6,      // history length, 1..IDX_W
    parameter int          MODE     = 1,      // 0 static not-taken, 1 bimodal, 2 gshare, 3 treated as 0
    parameter logic [1:0]  CNT_INIT = 2'b01   // reset value of every counter
) (
    input  logic             clk,
    input  logic             rst,

    // D-stage lookup
    input  logic             lookup_enD,
    input  logic             stallD,
    input  logic [31:0]      pcD,
    output logic             predict_takeD,
    output logic [GHR_W-1:0] ghr_snapD,

    // E-stage resolution
    input  logic             update_enE,
    input  logic [31:0]      pcE,
    input  logic             takenE,
    input  logic             predictedE,
    input  logic [GHR_W-1:0] ghr_snapE,
    output logic             mispredictE,

    // debug statistics
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam int ENTRIES    = 1 << IDX_W;
    // MODE 3 is an illegal setting and falls back to the static predictor.
    localparam bit USE_PHT    = (MODE == 1) || (MODE == 2);
    localparam bit USE_GSHARE = (MODE == 2);

    // Pattern history table and its next-state image.
    logic [1:0]       pht_q [ENTRIES];
    logic [1:0]       pht_d [ENTRIES];

    logic [GHR_W-1:0] ghr_q,         ghr_d;
    logic [31:0]      branch_cnt_q,  branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] idx_lookup;
    logic [IDX_W-1:0] idx_update;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;

    // History concatenated with the new outcome; the low GHR_W bits are the
    // shifted history. This form also covers GHR_W = 1, where the shift just
    // replaces the single bit.
    logic [GHR_W:0]   repair_cat;
    logic [GHR_W:0]   spec_cat;

    // PC bits outside the index field, and the dropped history MSB, are
    // intentionally ignored.
    logic             unused_bits;
    assign unused_bits = ^{pcD[31:IDX_W+2], pcD[1:0], pcE[31:IDX_W+2], pcE[1:0],
                           repair_cat[GHR_W], spec_cat[GHR_W]};

    // Bimodal index is the word-aligned PC field; gshare folds in the history
    // (zero-extended so a short history only perturbs the low index bits).
    function automatic logic [IDX_W-1:0] pht_index(input logic [31:0]      pc,
                                                   input logic [GHR_W-1:0] hist);
        logic [IDX_W-1:0] hist_ext;
        logic [IDX_W-1:0] idx;
        hist_ext             = '0;
        hist_ext[GHR_W-1:0]  = hist;
        idx                  = pc[IDX_W+1:2];
        if (USE_GSHARE) begin
            idx = idx ^ hist_ext;
        end
        return idx;
    endfunction

    // D-stage lookup: read the counter selected by pcD and the live history.
    always_comb begin
        idx_lookup    = pht_index(pcD, ghr_q);
        predict_takeD = 1'b0;
        if (USE_PHT) begin
            predict_takeD = pht_q[idx_lookup][1];
        end
        ghr_snapD     = ghr_q;
    end

    // E-stage resolution: mispredict flag and the saturating step for the
    // trained entry, indexed with the snapshot taken in D (never the live GHR).
    always_comb begin
        mispredictE = update_enE & (takenE != predictedE);
        idx_update  = pht_index(pcE, ghr_snapE);
        upd_cur     = pht_q[idx_update];
        upd_next    = upd_cur;
        if (takenE) begin
            if (upd_cur != 2'b11) begin
                upd_next = upd_cur + 2'b01;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_next = upd_cur - 2'b01;
            end
        end
    end

    // Counter training: at most one entry changes per cycle. The lookup above
    // reads pht_q, so a same-cycle collision returns the pre-update value.
    always_comb begin
        pht_d = pht_q;
        if (USE_PHT && update_enE) begin
            pht_d[idx_update] = upd_next;
        end
    end

    // History: mispredict repair beats the speculative shift, since the D
    // stage is being flushed in that cycle anyway.
    always_comb begin
        repair_cat = {ghr_snapE, takenE};
        spec_cat   = {ghr_q, predict_takeD};
        ghr_d      = ghr_q;
        if (mispredictE) begin
            ghr_d = repair_cat[GHR_W-1:0];
        end else if (lookup_enD && !stallD) begin
            ghr_d = spec_cat[GHR_W-1:0];
        end
    end

    // Statistics: free-running, wrap at 2^32.
    always_comb begin
        branch_cnt_d  = branch_cnt_q  + {31'd0, update_enE};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mispredictE};
    end

    // State registers; reset wins over any same-cycle update or lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
            end
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pht_q         <= pht_d;
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
